tmcu_uart_x: RTL and testbench

Parametrised, runtime-configurable UART for the t-mcu peripheral bus. It supersedes the fixed 8N1 UART with:
- a programmable divisor feeding a 16x oversampling tick;
- selectable data width, parity and stop bits;
- majority-vote mid-bit RX sampling with false-start rejection;
- parity, framing and overrun error reporting;
- a show-ahead RX FIFO behind a valid/ready handshake.

---
 rtl/tmcu_uart_pkg.sv | 42 ++++
 rtl/tmcu_sync_fifo.sv | 71 +++++++
 rtl/tmcu_uart_x.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_tmcu_uart_x.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmcu_uart_pkg.sv
// Shared types and constants for the t-mcu configurable UART.
//   parity_e     : decoded parity mode (cfg encoding 2'b11 also means none)
//   tx_state_e   : transmit frame sequencer states
//   rx_state_e   : receive frame sequencer states
//   OVERSAMPLE   : ticks per bit; SAMPLE_MID : tick index of the bit centre
package tmcu_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Map the raw 2-bit config field onto a parity mode.
  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tmcu_sync_fifo.sv
// Show-ahead synchronous FIFO.
//   push/wdata : write an entry (ignored when full unless popped same cycle)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : head entry, valid whenever empty=0
//   full/empty/level : registered occupancy status
module tmcu_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             wr_c, rd_c;

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  always_comb begin
    rd_c    = pop && !empty_q;
    wr_c    = push && (!full_q || rd_c);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_c) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);
    end
    if (rd_c) rptr_d = rptr_q + AW'(1);
    count_d = count_q + LW'(wr_c) - LW'(rd_c);
    full_d  = (count_d == LW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = count_q;

endmodule

// File: rtl/tmcu_uart_x.sv
// Runtime-configurable UART: programmable 16x divisor, 5..8 data bits,
// none/even/odd parity, 1/2 TX stop bits, majority-vote RX with false-start
// rejection and a show-ahead RX FIFO with parity/framing/overrun status.
//   cfg_*              : divisor, parity mode, TX stop-bit count
//   tx_valid/ready/data: TX byte handshake; tx is the registered serial line
//   rx                 : asynchronous serial input
//   rx_valid/ready/... : RX FIFO head and pop handshake, rx_level occupancy
//   rx_overrun         : sticky drop flag, cleared by clr_overrun
module tmcu_uart_x
  import tmcu_uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned RX_FIFO_DEPTH = 8,
  parameter int unsigned DIV_W         = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIV_W-1:0]                 cfg_baud_div,
  input  logic [1:0]                       cfg_parity,
  input  logic                             cfg_stop2,
  input  logic                             tx_valid,
  input  logic [DATA_BITS-1:0]             tx_data,
  output logic                             tx_ready,
  output logic                             tx,
  input  logic                             rx,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             rx_parity_err,
  output logic                             rx_frame_err,
  output logic                             rx_overrun,
  input  logic                             clr_overrun,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level
);

  localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned ENT_W = DATA_BITS + 2;
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  // Terminal count of the tick divider; a divisor of 0 behaves as 1.
  logic [DIV_W-1:0] div_last_c;
  always_comb div_last_c = (cfg_baud_div == '0) ? '0 : cfg_baud_div - DIV_W'(1);

  // ---------------- TX ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [DIV_W-1:0]     tx_div_q, tx_div_d;
  logic [PH_W-1:0]      tx_phase_q, tx_phase_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_pbit_q, tx_pbit_d, tx_par_en_q, tx_par_en_d;
  logic                 tx_stop2_q, tx_stop2_d, tx_q, tx_d, tx_ready_q, tx_ready_d;
  logic                 tx_tick_c;

  // The TX divider restarts on accept so every bit lasts exactly 16 ticks.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_div_d    = tx_div_q;
    tx_phase_d  = tx_phase_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_pbit_d   = tx_pbit_q;
    tx_par_en_d = tx_par_en_q;
    tx_stop2_d  = tx_stop2_q;
    tx_d        = tx_q;
    tx_ready_d  = tx_ready_q;
    tx_tick_c   = (tx_div_q >= div_last_c);
    if (tx_state_q == TX_IDLE) begin
      tx_div_d   = '0;
      tx_phase_d = '0;
      if (tx_valid && tx_ready_q) begin
        tx_state_d  = TX_START;
        tx_shift_d  = tx_data;
        tx_par_en_d = (decode_parity(cfg_parity) != PAR_NONE);
        tx_pbit_d   = (^tx_data) ^ (decode_parity(cfg_parity) == PAR_ODD);
        tx_stop2_d  = cfg_stop2;
        tx_bit_d    = '0;
        tx_d        = 1'b0;
        tx_ready_d  = 1'b0;
      end
    end else begin
      tx_div_d = tx_tick_c ? '0 : tx_div_q + DIV_W'(1);
      if (tx_tick_c) begin
        tx_phase_d = tx_phase_q + PH_W'(1);
        if (tx_phase_q == PH_LAST) begin
          case (tx_state_q)
            TX_START: begin
              tx_state_d = TX_DATA;
              tx_d       = tx_shift_q[0];
            end
            TX_DATA: begin
              if (tx_bit_q == BIT_LAST) begin
                tx_bit_d = '0;
                if (tx_par_en_q) begin
                  tx_state_d = TX_PARITY;
                  tx_d       = tx_pbit_q;
                end else begin
                  tx_state_d = TX_STOP;
                  tx_d       = 1'b1;
                end
              end else begin
                tx_bit_d   = tx_bit_q + BIT_W'(1);
                tx_shift_d = tx_shift_q >> 1;
                tx_d       = tx_shift_q[1];
              end
            end
            TX_PARITY: begin
              tx_state_d = TX_STOP;
              tx_d       = 1'b1;
            end
            TX_STOP: begin
              // tx_bit_q counts stop bits here.
              if (tx_stop2_q && (tx_bit_q == '0)) begin
                tx_bit_d = BIT_W'(1);
              end else begin
                tx_state_d = TX_IDLE;
                tx_ready_d = 1'b1;
              end
            end
            default: tx_state_d = TX_IDLE;
          endcase
        end
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic                 rx_s1_q, rx_s2_q;
  logic [DIV_W-1:0]     rx_div_q, rx_div_d;
  logic [PH_W-1:0]      rx_phase_q, rx_phase_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  parity_e              rx_par_q, rx_par_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [1:0]           rx_samp_q, rx_samp_d;
  logic                 rx_tick_c, maj_c, push_c;
  logic [ENT_W-1:0]     push_data_c;

  // Falling edge in IDLE restarts divider and phase; bits decided at tick 9
  // from the samples of ticks 7, 8 and 9.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_div_d    = rx_div_q;
    rx_phase_d  = rx_phase_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_perr_d   = rx_perr_q;
    rx_samp_d   = rx_samp_q;
    push_c      = 1'b0;
    push_data_c = '0;
    rx_tick_c   = (rx_div_q >= div_last_c);
    maj_c       = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_s2_q) |
                  (rx_samp_q[1] & rx_s2_q);
    if (rx_state_q == RX_IDLE) begin
      rx_div_d   = '0;
      rx_phase_d = '0;
      if (!rx_s2_q) begin
        rx_state_d = RX_START;
        rx_par_d   = decode_parity(cfg_parity);
        rx_perr_d  = 1'b0;
        rx_bit_d   = '0;
      end
    end else begin
      rx_div_d = rx_tick_c ? '0 : rx_div_q + DIV_W'(1);
      if (rx_tick_c) begin
        rx_phase_d = rx_phase_q + PH_W'(1);
        if (rx_phase_q == PH_W'(SAMPLE_MID - 1)) rx_samp_d[0] = rx_s2_q;
        if (rx_phase_q == PH_W'(SAMPLE_MID))     rx_samp_d[1] = rx_s2_q;
        case (rx_state_q)
          RX_START: begin
            if ((rx_phase_q == PH_W'(SAMPLE_MID)) && rx_s2_q) rx_state_d = RX_IDLE;
            else if (rx_phase_q == PH_LAST)                   rx_state_d = RX_DATA;
          end
          RX_DATA: begin
            if (rx_phase_q == PH_W'(SAMPLE_MID + 1))
              rx_shift_d = {maj_c, rx_shift_q[DATA_BITS-1:1]};
            if (rx_phase_q == PH_LAST) begin
              if (rx_bit_q == BIT_LAST) begin
                rx_bit_d   = '0;
                rx_state_d = (rx_par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
              end else begin
                rx_bit_d = rx_bit_q + BIT_W'(1);
              end
            end
          end
          RX_PARITY: begin
            if (rx_phase_q == PH_W'(SAMPLE_MID + 1))
              rx_perr_d = maj_c ^ (^rx_shift_q) ^ (rx_par_q == PAR_ODD);
            if (rx_phase_q == PH_LAST) rx_state_d = RX_STOP;
          end
          RX_STOP: begin
            if (rx_phase_q == PH_W'(SAMPLE_MID + 1)) begin
              rx_state_d  = RX_IDLE;
              push_c      = 1'b1;
              push_data_c = {~maj_c, rx_perr_q, rx_shift_q};
            end
          end
          default: rx_state_d = RX_IDLE;
        endcase
      end
    end
  end

  // ---------------- FIFO and overrun ----------------
  logic [ENT_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, rx_overrun_q, rx_overrun_d;

  tmcu_sync_fifo #(.WIDTH(ENT_W), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (push_data_c),
    .pop   (rx_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (rx_level)
  );

  // A new drop outranks a clear in the same cycle.
  always_comb rx_overrun_d = (rx_overrun_q && !clr_overrun) ||
                             (push_c && fifo_full && !rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= TX_IDLE;
      tx_div_q     <= '0;
      tx_phase_q   <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_pbit_q    <= 1'b0;
      tx_par_en_q  <= 1'b0;
      tx_stop2_q   <= 1'b0;
      tx_q         <= 1'b1;
      tx_ready_q   <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_div_q     <= '0;
      rx_phase_q   <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_q     <= PAR_NONE;
      rx_perr_q    <= 1'b0;
      rx_samp_q    <= 2'b11;
      rx_overrun_q <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_div_q     <= tx_div_d;
      tx_phase_q   <= tx_phase_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_pbit_q    <= tx_pbit_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_q         <= tx_d;
      tx_ready_q   <= tx_ready_d;
      rx_state_q   <= rx_state_d;
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_div_q     <= rx_div_d;
      rx_phase_q   <= rx_phase_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_q     <= rx_par_d;
      rx_perr_q    <= rx_perr_d;
      rx_samp_q    <= rx_samp_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign tx            = tx_q;
  assign tx_ready      = tx_ready_q;
  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_rdata[DATA_BITS-1:0];
  assign rx_parity_err = fifo_rdata[DATA_BITS];
  assign rx_frame_err  = fifo_rdata[DATA_BITS+1];
  assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_tmcu_uart_x.sv
// Self-checking bench for tmcu_uart_x: an 8-bit instance (TX line checks,
// loopback, injected RX frames, overrun, async reset) and a 7-bit instance
// looped back on itself.
`timescale 1ns/1ps
module tb_tmcu_uart_x;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] cfg_baud_div;
  logic [1:0]       cfg_parity;
  logic             cfg_stop2;
  logic             tx_valid, tx_ready, tx;
  logic [7:0]       tx_data;
  logic             rx_line, rx_drv, loop_en;
  logic             rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun, clr_overrun;
  logic [7:0]       rx_data;
  logic [3:0]       rx_level;

  logic             tx_valid7, tx_ready7, tx7, rx_valid7, rx_ready7, perr7, ferr7, ovr7;
  logic [6:0]       tx_data7, rx_data7;
  logic [3:0]       level7;

  int checks = 0;
  int failures = 0;

  // Reference frame: line bits in transmit order.
  logic exp_bits [16];
  int   exp_n;
  logic [7:0] ovr_bytes [DEPTH+1];

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  tmcu_uart_x #(.DATA_BITS(8), .RX_FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_baud_div(cfg_baud_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx(tx), .rx(rx_line), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
    .clr_overrun(clr_overrun), .rx_level(rx_level)
  );

  tmcu_uart_x #(.DATA_BITS(7), .RX_FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut7 (
    .clk(clk), .rst_n(rst_n), .cfg_baud_div(cfg_baud_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx_valid(tx_valid7), .tx_data(tx_data7), .tx_ready(tx_ready7),
    .tx(tx7), .rx(tx7), .rx_valid(rx_valid7), .rx_ready(rx_ready7), .rx_data(rx_data7),
    .rx_parity_err(perr7), .rx_frame_err(ferr7), .rx_overrun(ovr7),
    .clr_overrun(clr_overrun), .rx_level(level7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_period();
    return 16 * ((cfg_baud_div == '0) ? 1 : int'(cfg_baud_div));
  endfunction

  // Start, LSB-first data, optional parity, one or two stop bits.
  task automatic build_frame(input logic [7:0] d, input int nb, input logic [1:0] par,
                             input logic st2);
    int ones;
    ones = 0;
    exp_bits[0] = 1'b0;
    exp_n = 1;
    for (int i = 0; i < nb; i++) begin
      exp_bits[exp_n] = d[i];
      ones += int'(d[i]);
      exp_n++;
    end
    if (par == 2'b01) begin
      exp_bits[exp_n] = (ones % 2 == 1);
      exp_n++;
    end else if (par == 2'b10) begin
      exp_bits[exp_n] = (ones % 2 == 0);
      exp_n++;
    end
    exp_bits[exp_n] = 1'b1;
    exp_n++;
    if (st2) begin
      exp_bits[exp_n] = 1'b1;
      exp_n++;
    end
  endtask

  // Offer one byte and check every bit centre and the tx_ready low time.
  task automatic tx_frame(input int sel, input logic [7:0] b, input int nb, input string tag);
    int bp, n, low;
    logic cur_tx, cur_rdy;
    bp = bit_period();
    build_frame(b, nb, cfg_parity, cfg_stop2);
    @(negedge clk);
    if (sel == 1) begin tx_valid7 = 1'b1; tx_data7 = b[6:0]; end
    else          begin tx_valid  = 1'b1; tx_data  = b;      end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_valid7 = 1'b0;
    cur_tx  = (sel == 1) ? tx7 : tx;
    cur_rdy = (sel == 1) ? tx_ready7 : tx_ready;
    chk({tag, "_start_low"}, 32'(cur_tx), 32'(0));
    n = 0;
    low = 0;
    while (cur_rdy === 1'b0 && n < bp * 14) begin
      if ((n % bp) == bp / 2)
        chk($sformatf("%s_bit%0d", tag, n / bp), 32'(cur_tx),
            (n / bp < exp_n) ? 32'(exp_bits[n / bp]) : 32'(1));
      low++;
      n++;
      @(negedge clk);
      cur_tx  = (sel == 1) ? tx7 : tx;
      cur_rdy = (sel == 1) ? tx_ready7 : tx_ready;
    end
    chk({tag, "_ready_low_clks"}, 32'(low), 32'(bp * exp_n));
  endtask

  // Drive the current reference frame onto the 8-bit instance's rx pin.
  task automatic rx_send();
    int bp;
    bp = bit_period();
    for (int i = 0; i < exp_n; i++) begin
      rx_drv = exp_bits[i];
      repeat (bp) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(rx_valid), 32'(1));
    chk({tag, "_data"}, 32'(rx_data), 32'(d));
    chk({tag, "_perr"}, 32'(rx_parity_err), 32'(pe));
    chk({tag, "_ferr"}, 32'(rx_frame_err), 32'(fe));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;
    rst_n = 1'b0;
    cfg_baud_div = DIV_W'(2);
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    tx_valid7 = 1'b0; tx_data7 = '0;
    rx_ready = 1'b0; rx_ready7 = 1'b0;
    clr_overrun = 1'b0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_perr", 32'(rx_parity_err), 32'(0));
    chk("rst_ferr", 32'(rx_frame_err), 32'(0));
    chk("rst_overrun", 32'(rx_overrun), 32'(0));
    chk("rst_level", 32'(rx_level), 32'(0));
    chk("rst_tx7", 32'(tx7), 32'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5 at div 2: 32 clk per bit, 320 clk busy
    tx_frame(0, 8'hA5, 8, "a5_8n1");
    chk("a5_no_rx", 32'(rx_valid), 32'(0));

    // Loopback, even parity, two stop bits
    loop_en = 1'b1;
    cfg_parity = 2'b01;
    cfg_stop2 = 1'b1;
    tx_frame(0, 8'h00, 8, "lb00");
    pop_check("lb00", 8'h00, 1'b0, 1'b0);
    tx_frame(0, 8'hFF, 8, "lbff");
    pop_check("lbff", 8'hFF, 1'b0, 1'b0);
    tx_frame(0, 8'h5A, 8, "lb5a");
    pop_check("lb5a", 8'h5A, 1'b0, 1'b0);

    // Randomised loopback over divisor, parity and stop configuration
    for (int i = 0; i < 6; i++) begin
      cfg_baud_div = DIV_W'($urandom_range(1, 3));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2 = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      tx_frame(0, b, 8, $sformatf("rnd%0d", i));
      pop_check($sformatf("rnd%0d", i), b, 1'b0, 1'b0);
    end

    // Injected frames: wrong parity, then stop bit forced low (odd mode)
    loop_en = 1'b0;
    cfg_baud_div = DIV_W'(2);
    cfg_parity = 2'b10;
    cfg_stop2 = 1'b0;
    build_frame(8'h3C, 8, 2'b10, 1'b0);
    exp_bits[9] = ~exp_bits[9];
    rx_send();
    pop_check("perr3c", 8'h3C, 1'b1, 1'b0);
    repeat (2 * bit_period()) @(negedge clk);
    build_frame(8'h3C, 8, 2'b10, 1'b0);
    exp_bits[exp_n - 1] = 1'b0;
    rx_send();
    repeat (2 * bit_period()) @(negedge clk);
    chk("ferr_level_one", 32'(rx_level), 32'(1));
    pop_check("ferr3c", 8'h3C, 1'b0, 1'b1);
    chk("ferr_drained", 32'(rx_valid), 32'(0));

    // Short low pulse (4 ticks) is rejected; next frame is intact
    cfg_parity = 2'b00;
    rx_drv = 1'b0;
    repeat (4 * 2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * bit_period()) @(negedge clk);
    chk("glitch_no_push", 32'(rx_level), 32'(0));
    build_frame(8'h81, 8, 2'b00, 1'b0);
    rx_send();
    pop_check("after_glitch81", 8'h81, 1'b0, 1'b0);

    // Overrun: DEPTH+1 frames without popping
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      ovr_bytes[i] = 8'($urandom);
      build_frame(ovr_bytes[i], 8, 2'b00, 1'b0);
      rx_send();
    end
    repeat (4) @(negedge clk);
    chk("ovr_level_full", 32'(rx_level), 32'(DEPTH));
    chk("ovr_flag_set", 32'(rx_overrun), 32'(1));
    for (int i = 0; i < int'(DEPTH); i++)
      pop_check($sformatf("ovr_pop%0d", i), ovr_bytes[i], 1'b0, 1'b0);
    chk("ovr_level_empty", 32'(rx_level), 32'(0));
    chk("ovr_sticky", 32'(rx_overrun), 32'(1));
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    chk("ovr_cleared", 32'(rx_overrun), 32'(0));

    // 7O1 on the 7-bit instance: 0x55 has four ones, so parity bit is 1
    cfg_parity = 2'b10;
    tx_frame(1, 8'h55, 7, "d7_55");
    chk("d7_parity_bit", 32'(exp_bits[8]), 32'(1));
    n = 0;
    while (rx_valid7 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("d7_valid", 32'(rx_valid7), 32'(1));
    chk("d7_data", 32'(rx_data7), 32'(7'h55));
    chk("d7_perr", 32'(perr7), 32'(0));
    chk("d7_ferr", 32'(ferr7), 32'(0));

    // Asynchronous reset in the middle of a TX frame with an RX entry pending
    cfg_parity = 2'b00;
    build_frame(8'h33, 8, 2'b00, 1'b0);
    rx_send();
    repeat (2) @(negedge clk);
    chk("pre_rst_level", 32'(rx_level), 32'(1));
    tx_valid = 1'b1;
    tx_data = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_tx_low", 32'(tx), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'(1));
    chk("async_rst_ready", 32'(tx_ready), 32'(1));
    chk("async_rst_level", 32'(rx_level), 32'(0));
    chk("async_rst_valid", 32'(rx_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
